// File: rtl/ita_hwpe_output_packer_if.sv
// Stream bundle between the ITA engine output, the packer and the HWPE sink streamer.
// Every stream transfers on a rising edge where valid and ready are both 1; a producer keeps valid and its payload stable until that edge, and valid never waits on ready.
interface ita_hwpe_output_packer_if #(
  parameter int unsigned IN_DW  = 128,
  parameter int unsigned OUT_DW = 1024
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_DW-1:0]      in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_DW-1:0]     out_data;
  logic [OUT_DW/8-1:0]   out_strb;
  logic                  out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_strb, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_strb, out_last
  );
endinterface

// File: rtl/ita_hwpe_output_packer.sv
// Packs narrow engine output beats into TCDM-width words with byte strobes and a last flag,
// or swallows a whole job when its output is disabled.
module ita_hwpe_output_packer #(
  parameter int unsigned IN_DW  = 128,
  parameter int unsigned OUT_DW = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    output_disable_i,
  input  logic                    start_i,
  ita_hwpe_output_packer_if.slave bus,
  output logic                    busy_o,
  output logic [15:0]             word_cnt_o
);
  localparam int unsigned RATIO  = OUT_DW / IN_DW;
  localparam int unsigned SW     = $clog2(RATIO);
  localparam int unsigned IN_SB  = IN_DW / 8;
  localparam int unsigned OUT_SB = OUT_DW / 8;
  localparam logic [SW:0] LAST_SLOT = (SW + 1)'(RATIO - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [SW:0]                    slot_q, slot_d;
  logic [RATIO-1:0][IN_DW-1:0]    asm_data_q, asm_data_d;
  logic [RATIO-1:0][IN_SB-1:0]    asm_strb_q, asm_strb_d;
  logic                           asm_last_q, asm_last_d;
  logic                           dis_q, dis_d;
  logic                           ov_q, ov_d;
  logic [OUT_DW-1:0]              od_q, od_d;
  logic [OUT_SB-1:0]              os_q, os_d;
  logic                           ol_q, ol_d;
  logic [15:0]                    cnt_q, cnt_d;

  logic                           in_ready;
  logic                           in_fire;
  logic                           out_fire;
  logic                           drain;
  logic                           complete;
  logic [SW-1:0]                  slot_idx;
  logic [RATIO-1:0][IN_DW-1:0]    merged_data;
  logic [RATIO-1:0][IN_SB-1:0]    merged_strb;

  assign slot_idx = slot_q[SW-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= FILL;
      slot_q     <= '0;
      asm_data_q <= '0;
      asm_strb_q <= '0;
      asm_last_q <= 1'b0;
      dis_q      <= 1'b0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      os_q       <= '0;
      ol_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      asm_data_q <= asm_data_d;
      asm_strb_q <= asm_strb_d;
      asm_last_q <= asm_last_d;
      dis_q      <= dis_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      os_q       <= os_d;
      ol_q       <= ol_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    asm_data_d  = asm_data_q;
    asm_strb_d  = asm_strb_q;
    asm_last_d  = asm_last_q;
    dis_d       = dis_q;
    ov_d        = ov_q;
    od_d        = od_q;
    os_d        = os_q;
    ol_d        = ol_q;
    cnt_d       = cnt_q;
    complete    = 1'b0;
    merged_data = asm_data_q;
    merged_strb = asm_strb_q;

    // A disabled job must never stall the engine, even with a word still held.
    in_ready = dis_q || (state_q != HOLD);
    in_fire  = bus.in_valid && in_ready;
    out_fire = ov_q && bus.out_ready;
    drain    = !ov_q || bus.out_ready;

    merged_data[slot_idx] = bus.in_data;
    merged_strb[slot_idx] = '1;

    if (out_fire) begin
      ov_d = 1'b0;
    end

    if (dis_q && in_fire && bus.in_last) begin
      dis_d = 1'b0;
    end

    if (state_q == HOLD) begin
      if (drain) begin
        ov_d       = 1'b1;
        od_d       = asm_data_q;
        os_d       = asm_strb_q;
        ol_d       = asm_last_q;
        asm_data_d = '0;
        asm_strb_d = '0;
        asm_last_d = 1'b0;
        slot_d     = '0;
        state_d    = FILL;
      end
    end else if (in_fire && !dis_q) begin
      complete = (slot_q == LAST_SLOT) || bus.in_last;
      if (!complete) begin
        asm_data_d = merged_data;
        asm_strb_d = merged_strb;
        slot_d     = slot_q + 1'b1;
      end else if (drain) begin
        // Straight through: the completed word bypasses the assembly register.
        ov_d       = 1'b1;
        od_d       = merged_data;
        os_d       = merged_strb;
        ol_d       = bus.in_last;
        asm_data_d = '0;
        asm_strb_d = '0;
        asm_last_d = 1'b0;
        slot_d     = '0;
      end else begin
        asm_data_d = merged_data;
        asm_strb_d = merged_strb;
        asm_last_d = bus.in_last;
        slot_d     = slot_q + 1'b1;
        state_d    = HOLD;
      end
    end

    if (start_i) begin
      dis_d = output_disable_i;
      cnt_d = '0;
    end else if (out_fire) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_strb  = os_q;
  assign bus.out_last  = ol_q;
  assign busy_o        = (slot_q != '0) || ov_q;
  assign word_cnt_o    = cnt_q;

endmodule

// File: tb/tb_ita_hwpe_output_packer.sv
// Bench for ita_hwpe_output_packer: directed corner sequences, a table of jobs and random jobs,
// all words checked against a queue-based packing model.
module tb_ita_hwpe_output_packer;
  localparam int IN_DW  = 128;
  localparam int OUT_DW = 1024;
  localparam int RATIO  = OUT_DW / IN_DW;
  localparam int BB     = IN_DW / 8;
  localparam int SB     = OUT_DW / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        output_disable = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [15:0] word_cnt;

  ita_hwpe_output_packer_if #(.IN_DW(IN_DW), .OUT_DW(OUT_DW)) bus ();

  ita_hwpe_output_packer #(.IN_DW(IN_DW), .OUT_DW(OUT_DW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_i          (clear),
    .output_disable_i (output_disable),
    .start_i          (start),
    .bus              (bus),
    .busy_o           (busy),
    .word_cnt_o       (word_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  // Reference model: accepted beats, expected words in emission order, expected count.
  logic [IN_DW-1:0]  beats[$];
  logic [OUT_DW-1:0] exp_q[$];
  logic [SB-1:0]     exp_s_q[$];
  logic              exp_l_q[$];
  bit                m_dis = 1'b0;
  logic [15:0]       m_cnt = '0;

  typedef struct {
    int          n;
    bit          dis;
    logic [15:0] exp_cnt;
  } job_vec_t;

  job_vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IN_DW-1:0] rand_beat();
    logic [IN_DW-1:0] r;
    for (int i = 0; i < IN_DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    bus.out_ready = 1'b1;
    while (busy && t < 300) begin
      tick(1);
      t++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", t);
    end
  endtask

  task automatic do_start(input bit dis);
    wait_idle();
    start = 1'b1;
    output_disable = dis;
    tick(1);
    start = 1'b0;
    output_disable = 1'b0;
  endtask

  task automatic send_beat(input logic [IN_DW-1:0] d, input logic l);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_beat: in_ready stuck at 0 for %0d cycles", t);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // One job of n beats with optional random valid gaps and sink backpressure.
  task automatic run_job(input int n, input bit rnd);
    int idx = 0;
    int t = 0;
    logic [IN_DW-1:0] d;
    d = rand_beat();
    while (idx < n && t < 3000) begin
      bus.in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data   = d;
      bus.in_last   = (idx == n - 1);
      bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        d = rand_beat();
      end
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (idx < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_job: only %0d of %0d beats accepted", idx, n);
    end
  endtask

  always @(negedge clk) begin
    logic [RATIO-1:0][IN_DW-1:0] wd;
    logic [SB-1:0]               ws;
    logic [OUT_DW-1:0]           ed;
    logic [SB-1:0]               es;
    logic                        el;
    int                          nb;
    if (mon_en) begin
      n_tests++;
      if (word_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL word_cnt: got %0d, expected %0d", word_cnt, m_cnt);
      end
    end
    if (!rst && !clear && start) assert (!busy) else $error("start_i raised while busy_o=1");
    if (rst || clear) begin
      beats.delete();
      exp_q.delete();
      exp_s_q.delete();
      exp_l_q.delete();
      m_dis = 1'b0;
      m_cnt = '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: unexpected word data[127:0]=%h", bus.out_data[127:0]);
        end else begin
          ed = exp_q.pop_front();
          es = exp_s_q.pop_front();
          el = exp_l_q.pop_front();
          if (bus.out_data !== ed || bus.out_strb !== es || bus.out_last !== el) begin
            n_fail++;
            $display("FAIL sb_word: got data[127:0]=%h strb=%h last=%b, expected data[127:0]=%h strb=%h last=%b",
                     bus.out_data[127:0], bus.out_strb, bus.out_last, ed[127:0], es, el);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (m_dis) begin
          if (bus.in_last) m_dis = 1'b0;
        end else begin
          beats.push_back(bus.in_data);
          if (beats.size() == RATIO || bus.in_last) begin
            wd = '0;
            ws = '0;
            nb = beats.size();
            for (int k = 0; k < nb; k++) wd[k] = beats[k];
            for (int b = 0; b < nb * BB; b++) ws[b] = 1'b1;
            exp_q.push_back(wd);
            exp_s_q.push_back(ws);
            exp_l_q.push_back(bus.in_last);
            beats.delete();
          end
        end
      end
      if (start) begin
        m_dis = output_disable;
        m_cnt = '0;
      end else if (bus.out_valid && bus.out_ready) begin
        m_cnt = m_cnt + 16'd1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RATIO-1:0][IN_DW-1:0] e1w;
    logic [IN_DW-1:0]            b;
    logic [IN_DW-1:0]            bt[24];
    logic [SB-1:0]               e2s;
    int                          idx;
    int                          bad;
    int                          t;

    vecs[0] = '{n: 1,  dis: 1'b0, exp_cnt: 16'd1};
    vecs[1] = '{n: 7,  dis: 1'b0, exp_cnt: 16'd1};
    vecs[2] = '{n: 8,  dis: 1'b0, exp_cnt: 16'd1};
    vecs[3] = '{n: 9,  dis: 1'b0, exp_cnt: 16'd2};
    vecs[4] = '{n: 16, dis: 1'b0, exp_cnt: 16'd2};
    vecs[5] = '{n: 17, dis: 1'b0, exp_cnt: 16'd3};
    vecs[6] = '{n: 13, dis: 1'b1, exp_cnt: 16'd0};
    vecs[7] = '{n: 24, dis: 1'b0, exp_cnt: 16'd3};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    mon_en = 1'b1;

    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data",  64'(|bus.out_data), 64'(0));
    check("rst_out_strb",  64'(|bus.out_strb), 64'(0));
    check("rst_out_last",  64'(bus.out_last), 64'(0));
    check("rst_busy",      64'(busy), 64'(0));
    check("rst_word_cnt",  64'(word_cnt), 64'(0));
    check("rst_in_ready",  64'(bus.in_ready), 64'(1));

    // Full word of byte patterns 1..8
    do_start(1'b0);
    e1w = '0;
    for (int k = 0; k < RATIO; k++) begin
      for (int y = 0; y < BB; y++) e1w[k][y*8 +: 8] = 8'(k + 1);
    end
    for (int k = 0; k < RATIO; k++) send_beat(e1w[k], k == RATIO - 1);
    check("t1_valid", 64'(bus.out_valid), 64'(1));
    check("t1_data",  64'(bus.out_data === e1w), 64'(1));
    check("t1_strb",  64'(&bus.out_strb), 64'(1));
    check("t1_last",  64'(bus.out_last), 64'(1));
    tick(1);
    check("t1_word_cnt", 64'(word_cnt), 64'(1));
    check("t1_drained",  64'(bus.out_valid), 64'(0));

    // Partial last word of three beats
    do_start(1'b0);
    for (int k = 0; k < 3; k++) send_beat(rand_beat(), k == 2);
    e2s = '0;
    for (int y = 0; y < 48; y++) e2s[y] = 1'b1;
    check("t2_valid",   64'(bus.out_valid), 64'(1));
    check("t2_strb",    64'(bus.out_strb === e2s), 64'(1));
    check("t2_hi_zero", 64'(|bus.out_data[OUT_DW-1:384]), 64'(0));
    check("t2_last",    64'(bus.out_last), 64'(1));

    // Backpressure: sink stalled for 30 cycles while 24 beats are offered
    do_start(1'b0);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 24; k++) bt[k] = rand_beat();
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      bus.in_valid = (idx < 24);
      bus.in_data  = (idx < 24) ? bt[idx] : '0;
      bus.in_last  = (idx == 23);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("t3_accepted", 64'(idx), 64'(16));
    check("t3_in_ready", 64'(bus.in_ready), 64'(0));
    check("t3_out_valid", 64'(bus.out_valid), 64'(1));
    bus.out_ready = 1'b1;
    t = 0;
    while (idx < 24 && t < 100) begin
      bus.in_valid = 1'b1;
      bus.in_data  = bt[idx];
      bus.in_last  = (idx == 23);
      @(negedge clk);
      if (bus.in_ready) idx++;
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("t3_all_accepted", 64'(idx), 64'(24));
    wait_idle();
    check("t3_word_cnt", 64'(word_cnt), 64'(3));

    // Disabled job: everything dropped, no stall
    do_start(1'b1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rand_beat();
      bus.in_last  = (k == 19);
      @(negedge clk);
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("t4_flags_bad_cycles", 64'(bad), 64'(0));
    tick(2);
    check("t4_word_cnt", 64'(word_cnt), 64'(0));
    check("t4_busy",     64'(busy), 64'(0));
    send_beat(rand_beat(), 1'b1);
    check("t4_latch_cleared", 64'(bus.out_valid), 64'(1));

    // Clear in the middle of a word
    do_start(1'b0);
    for (int k = 0; k < 5; k++) send_beat(rand_beat(), 1'b0);
    check("t5_busy_before", 64'(busy), 64'(1));
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t5_busy_after", 64'(busy), 64'(0));
    check("t5_word_cnt",   64'(word_cnt), 64'(0));
    b = rand_beat();
    send_beat(b, 1'b0);
    for (int k = 1; k < RATIO; k++) send_beat(rand_beat(), k == RATIO - 1);
    check("t5_valid", 64'(bus.out_valid), 64'(1));
    check("t5_slot0", 64'(bus.out_data[IN_DW-1:0] === b), 64'(1));

    // Completing beat accepted on the same edge the held word drains
    do_start(1'b0);
    bus.out_ready = 1'b0;
    for (int k = 0; k < RATIO; k++) send_beat(rand_beat(), k == RATIO - 1);
    b = rand_beat();
    send_beat(b, 1'b0);
    for (int k = 1; k < RATIO - 1; k++) send_beat(rand_beat(), 1'b0);
    check("t6_still_held", 64'(bus.out_valid), 64'(1));
    bus.out_ready = 1'b1;
    send_beat(rand_beat(), 1'b1);
    check("t6_no_bubble", 64'(bus.out_valid), 64'(1));
    check("t6_new_slot0", 64'(bus.out_data[IN_DW-1:0] === b), 64'(1));
    check("t6_word_cnt",  64'(word_cnt), 64'(1));

    // Reset on the edge of an out handshake
    do_start(1'b0);
    bus.out_ready = 1'b0;
    for (int k = 0; k < RATIO; k++) send_beat(rand_beat(), k == RATIO - 1);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("t6_rst_busy",      64'(busy), 64'(0));

    foreach (vecs[i]) begin
      do_start(vecs[i].dis);
      run_job(vecs[i].n, 1'b1);
      wait_idle();
      check($sformatf("vec%0d_word_cnt", i), 64'(word_cnt), 64'(vecs[i].exp_cnt));
    end

    for (int j = 0; j < 150; j++) begin
      do_start($urandom_range(0, 4) == 0);
      run_job($urandom_range(1, 40), 1'b1);
    end
    wait_idle();
    check("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ita_hwpe_output_packer.md
Name: ita_hwpe_output_packer

Overview:
Sits between the ITA engine output port and the HWPE output sink streamer. Collects narrow engine output beats (N*WI bits each) and packs them into full TCDM-width words. Emits each word with byte strobes and a last flag. Supports dropping output entirely when the output-disable control bit is set, so the sink never sees a transaction.

Parameters:
IN_DW, 128, engine output beat width (ITA_OUTPUT_DW); multiple of 8.
OUT_DW, 1024, TCDM word width (ITA_TCDM_DW); integer multiple of IN_DW.
RATIO, OUT_DW/IN_DW (derived, 8), beats per packed word; must be a power of two and at least 2.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous active-high reset.
clear_i  in  1  synchronous soft clear; same effect as reset.
output_disable_i  in  1  from ctrl_stream_t.output_disable; sampled on start_i.
start_i  in  1  one-cycle pulse at job start; latches output_disable_i.
in_valid_i  in  1  engine beat valid.
in_ready_o  out  1  engine beat ready.
in_data_i  in  IN_DW  engine beat.
in_last_i  in  1  final beat of the job.
out_valid_o  out  1  packed word valid to the sink.
out_ready_i  in  1  sink ready.
out_data_o  out  OUT_DW  packed word.
out_strb_o  out  OUT_DW/8  byte strobes.
out_last_o  out  1  final word of the job.
busy_o  out  1  partial data held, or output register valid.
word_cnt_o  out  16  words emitted since start_i; wraps at 2^16.

Behaviour:
- Reset values (rst_i or clear_i): out_valid_o=0, out_data_o=0, out_strb_o=0, out_last_o=0, busy_o=0, word_cnt_o=0, slot counter=0, assembly register=0, disable latch=0. in_ready_o is combinational.
- Clear and reset take priority over all other events in the same cycle, including a handshake in progress. In-flight data is discarded.
- Handshakes: a transfer occurs when valid and ready are both 1 on a rising edge. out_valid_o stays asserted, with out_data_o, out_strb_o and out_last_o held stable, until out_ready_i is 1. out_valid_o does not depend combinationally on out_ready_i.
- Packing order: the beat in slot k (k = 0..RATIO-1, first accepted beat is slot 0) lands in out_data bits [k*IN_DW +: IN_DW]. It enables strobe bytes [k*IN_DW/8 +: IN_DW/8].
- Assembly register (RATIO slots plus slot counter) feeds an output register. States:
  - FILL: accept beats while the slot counter is below RATIO.
  - A word is complete when the beat accepted is in slot RATIO-1, or in_last_i=1 on an accepted beat.
  - If the output register is empty, or is being consumed this cycle, the complete word moves into the output register on the same edge. out_valid_o rises the cycle after the completing handshake (latency 1). The slot counter returns to 0 and back-to-back words are accepted at full rate.
  - HOLD: otherwise the assembly register stays full and in_ready_o=0 until the output register drains; the transfer then happens on that drain edge.
- in_ready_o = disable_latch OR NOT(HOLD).
- Partial last word:
  - Only filled slots have strobes set.
  - Unfilled slots carry zero data.
  - out_last_o=1.
  - Slot counter resets to 0.
- A full word that completes with in_last_i=1 has all strobes set and out_last_o=1.
- Disabled job (disable latch = 1):
  - in_ready_o=1; every beat is accepted and dropped.
  - out_valid_o never asserts, word_cnt_o does not increment, busy_o=0.
  - The latch clears on in_last_i acceptance.
- start_i while busy_o=1 is a protocol error. The block latches the new output-disable value and continues packing existing data; benches flag it with an assertion.
- word_cnt_o increments on each out handshake. It is cleared by start_i, reset or clear. start_i and an out handshake in the same cycle give word_cnt_o=0.
- busy_o = (slot counter != 0) OR out_valid_o.

Test Plan:
1. Full word: out_ready_i=1, 8 beats with data 0x01..0x08 in every byte, last on the 8th beat -> one word, out_valid_o the cycle after the 8th handshake. Slot k bytes hold k+1; out_strb_o all ones; out_last_o=1; word_cnt_o=1.
2. Partial last: 3 beats, last on the 3rd -> out_strb_o has the lower 48 bits set and the rest 0. out_data_o bits [1023:384]=0; out_last_o=1.
3. Backpressure: out_ready_i=0 for 30 cycles, 24 beats offered -> exactly 16 beats accepted, then in_ready_o=0. After out_ready_i=1, two words drain in order, the remaining 8 beats are accepted, and word_cnt_o reaches 3.
4. Disable: start_i with output_disable_i=1, 20 beats, last on the 20th -> in_ready_o constantly 1; out_valid_o never 1; word_cnt_o=0; busy_o=0 throughout.
5. Clear mid-word: 5 beats accepted, then clear_i -> next cycle busy_o=0. Subsequent 8 beats yield one word whose slot 0 holds the first post-clear beat.
6. Simultaneous events: the 8th beat is accepted in the same cycle the held word is consumed -> the new word appears the next cycle with no bubble. rst_i asserted during an out handshake -> out_valid_o=0 the next cycle.
